// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: FIFO bus (clear/in/push/pop/thresholds from master; out/flags/num/peak/errors from slave)
interface sync_fifo_ctrl_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4
);
  logic              clear;
  logic [DWIDTH-1:0] in;
  logic              push;
  logic              pop;
  logic [AWIDTH:0]   ae_level;
  logic [AWIDTH:0]   af_level;
  logic [DWIDTH-1:0] out;
  logic              empty;
  logic              almostempty;
  logic              full;
  logic              almostfull;
  logic [AWIDTH:0]   num;
  logic [AWIDTH:0]   peak;
  logic              overflow;
  logic              underflow;
  modport master (
    output clear, in, push, pop, ae_level, af_level,
    input  out, empty, almostempty, full, almostfull, num, peak, overflow, underflow
  );
  modport slave (
    input  clear, in, push, pop, ae_level, af_level,
    output out, empty, almostempty, full, almostfull, num, peak, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with thresholds, FWFT mode, sticky errors, flush and peak; ports clk, reset (sync active-low), f (slave side of sync_fifo_ctrl_if)
module sync_fifo_ctrl #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 2**AWIDTH,
  parameter int FWFT   = 0
) (
  input logic             clk,
  input logic             reset,
  sync_fifo_ctrl_if.slave f
);
  localparam logic [AWIDTH:0] full_n = (AWIDTH+1)'(DEPTH);
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wptr, rptr;
  logic [AWIDTH:0]   num, peak, num_nxt;
  logic [DWIDTH-1:0] out_q;
  logic              ovf, unf, rd, wr, run;
  assign run     = reset & ~f.clear;
  assign rd      = f.pop & ~f.empty;
  assign wr      = f.push & (~f.full | rd);
  assign num_nxt = (wr & ~rd) ? num + 1'b1 : (rd & ~wr) ? num - 1'b1 : num;
  assign f.empty       = num == '0;
  assign f.full        = num == full_n;
  assign f.almostempty = num <= f.ae_level;
  assign f.almostfull  = num >= f.af_level;
  assign f.num         = num;
  assign f.peak        = peak;
  assign f.overflow    = ovf;
  assign f.underflow   = unf;
  assign f.out         = FWFT != 0 ? (f.empty ? '0 : mem[rptr]) : out_q;
  always_ff @(posedge clk)
    if (run && wr) mem[wptr] <= f.in;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      num   <= '0;
      peak  <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      out_q <= '0;
    end else if (f.clear) begin
      wptr <= '0;
      rptr <= '0;
      num  <= '0;
      peak <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      num  <= num_nxt;
      peak <= num_nxt > peak ? num_nxt : peak;
      if (f.push && f.full && !f.pop) ovf <= 1'b1;
      if (f.pop && f.empty) unf <= 1'b1;
      if (FWFT == 0 && rd) out_q <= mem[rptr];
    end
  end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed checks of sync_fifo_ctrl in registered (a) and FWFT (b) modes
module tb_sync_fifo_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  sync_fifo_ctrl_if #(.DWIDTH(16), .AWIDTH(4)) a ();
  sync_fifo_ctrl_if #(.DWIDTH(16), .AWIDTH(4)) b ();
  sync_fifo_ctrl #(.DWIDTH(16), .AWIDTH(4), .DEPTH(16), .FWFT(0)) u_a (.clk(clk), .reset(reset), .f(a.slave));
  sync_fifo_ctrl #(.DWIDTH(16), .AWIDTH(4), .DEPTH(16), .FWFT(1)) u_b (.clk(clk), .reset(reset), .f(b.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    {a.clear, a.push, a.pop, a.in} = '0;
    {b.clear, b.push, b.pop, b.in} = '0;
    a.ae_level = 5'd2;
    a.af_level = 5'd14;
    b.ae_level = 5'd2;
    b.af_level = 5'd14;
    step();
    step();
    reset = 1'b1;
    chk("rst_num", a.num, 0);
    chk("rst_empty", a.empty, 1);
    chk("rst_ae", a.almostempty, 1);
    chk("rst_full", a.full, 0);
    chk("rst_af", a.almostfull, 0);
    chk("rst_out", a.out, 0);
    chk("rst_peak", a.peak, 0);
    chk("rst_err", {a.overflow, a.underflow}, 0);
    a.push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a.in = 16'(i);
      step();
      if (i < 3) chk($sformatf("ae_%0d", i), a.almostempty, i < 2 ? 1 : 0);
      if (i == 12 || i == 13) chk($sformatf("af_%0d", i), a.almostfull, i == 13 ? 1 : 0);
    end
    chk("fill_num", a.num, 16);
    chk("fill_full", a.full, 1);
    chk("fill_af", a.almostfull, 1);
    chk("fill_peak", a.peak, 16);
    chk("fill_ovf", a.overflow, 0);
    a.in = 16'd16;
    step();
    chk("ovf_set", a.overflow, 1);
    chk("ovf_num", a.num, 16);
    a.pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a.in = 16'(100 + i);
      step();
      chk($sformatf("pp_out_%0d", i), a.out, i);
      chk($sformatf("pp_num_%0d", i), a.num, 16);
    end
    chk("pp_ovf", a.overflow, 1);
    a.push = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("drain_%0d", i), a.out, i < 8 ? 8 + i : 100 + i - 8);
    end
    chk("drain_empty", a.empty, 1);
    chk("drain_unf", a.underflow, 0);
    a.pop = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst2_out", a.out, 0);
    chk("rst2_ovf", a.overflow, 0);
    a.pop = 1'b1;
    step();
    chk("unf_set", a.underflow, 1);
    chk("unf_num", a.num, 0);
    chk("unf_out", a.out, 0);
    a.push = 1'b1;
    a.in = 16'd55;
    step();
    chk("pe_num", a.num, 1);
    chk("pe_unf", a.underflow, 1);
    a.push = 1'b0;
    step();
    chk("pe_out", a.out, 55);
    a.pop = 1'b0;
    a.push = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a.in = 16'(200 + i);
      step();
    end
    a.push = 1'b0;
    a.pop = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pre_clr_out", a.out, 204);
    chk("pre_clr_num", a.num, 5);
    a.clear = 1'b1;
    a.push = 1'b1;
    step();
    a.clear = 1'b0;
    a.push = 1'b0;
    a.pop = 1'b0;
    chk("clr_num", a.num, 0);
    chk("clr_empty", a.empty, 1);
    chk("clr_peak", a.peak, 0);
    chk("clr_err", {a.overflow, a.underflow}, 0);
    chk("clr_out", a.out, 204);
    a.push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a.in = 16'(i + 1);
      step();
    end
    a.in = 16'd9;
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_num", a.num, 0);
    chk("mid_peak", a.peak, 0);
    chk("mid_out", a.out, 0);
    chk("mid_empty", a.empty, 1);
    a.in = 16'd77;
    step();
    a.push = 1'b0;
    a.pop = 1'b1;
    step();
    a.pop = 1'b0;
    chk("mid_first", a.out, 77);
    a.af_level = 5'd0;
    #1;
    chk("thr_comb", a.almostfull, 1);
    chk("fw_empty0", b.empty, 1);
    chk("fw_out0", b.out, 0);
    b.push = 1'b1;
    b.in = 16'hABCD;
    step();
    chk("fw_out1", b.out, 16'hABCD);
    chk("fw_empty1", b.empty, 0);
    b.in = 16'h1234;
    step();
    b.push = 1'b0;
    chk("fw_hold", b.out, 16'hABCD);
    b.pop = 1'b1;
    step();
    chk("fw_next", b.out, 16'h1234);
    step();
    b.pop = 1'b0;
    chk("fw_empty2", b.empty, 1);
    chk("fw_out2", b.out, 0);
    chk("fw_unf", b.underflow, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Parametrised single-clock FIFO that generalises the team's synchronous FIFO. It adds:
- run-time programmable almost-empty/almost-full thresholds;
- a selectable first-word-fall-through (FWFT) read mode;
- sticky overflow/underflow error flags;
- a synchronous flush;
- a high-watermark occupancy register.

It sits between a producer/consumer pair in one clock domain and is the drop-in replacement wherever buffering with diagnostics is required.

## Interface
- DWIDTH, 16, data width in bits
- AWIDTH, 4, address width; pointers are AWIDTH bits
- DEPTH, 2**AWIDTH, storage depth; must equal 2**AWIDTH
- FWFT, 0, read mode: 0 = registered output, 1 = first-word-fall-through

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- clear  in  1  synchronous flush, active-high
- in  in  DWIDTH  write data
- push  in  1  write request
- pop  in  1  read request
- ae_level  in  AWIDTH+1  almost-empty threshold
- af_level  in  AWIDTH+1  almost-full threshold
- out  out  DWIDTH  read data
- empty  out  1  num == 0
- almostempty  out  1  num <= ae_level
- full  out  1  num == DEPTH
- almostfull  out  1  num >= af_level
- num  out  AWIDTH+1  current occupancy, 0..DEPTH
- peak  out  AWIDTH+1  maximum num since last reset/clear
- overflow  out  1  sticky: push attempted while full and not popping
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Reset (reset == 0 at an edge) has priority over everything.
  - Clears write pointer, read pointer, num, peak, overflow, underflow and out.
  - Flags after reset: empty = 1, almostempty = 1 (for ae_level ≥ 0), full = 0, almostfull = (af_level == 0). Storage contents are not cleared.
- clear = 1 (reset inactive) performs the same as reset, except out holds its value.
  - push/pop in the same cycle are discarded.
  - Error flags are not set by pushes/pops discarded under clear.
- Write accepted when push = 1 and (full = 0, or pop is also accepted that cycle).
  - mem[wptr] <= in, wptr increments modulo DEPTH.
- Read accepted when pop = 1 and empty = 0.
  - rptr increments modulo DEPTH.
- num: +1 on write only, −1 on read only, unchanged on both or neither. num is never outside 0..DEPTH.
- Full with push and pop together: both accepted, num stays DEPTH, overflow not set.
- Empty with push and pop together: the push is accepted, the pop is rejected, underflow is set, num becomes 1.
- push while full without pop: write dropped, overflow <= 1.
- pop while empty: read dropped, underflow <= 1.
- Sticky flags stay set until reset or clear.
- peak <= max(peak, next num) every cycle.
- Flags are combinational from registered num and the threshold inputs. Threshold changes take effect in the same cycle.
- FWFT = 0: on an accepted read, out <= mem[rptr] at that edge. Otherwise out holds.
- FWFT = 1: out = mem[rptr] combinationally whenever empty = 0, and out = 0 when empty = 1. An accepted pop advances to the next word.

## Timing
- Write at edge N: num/empty/flags reflect it after edge N.
  - The word is poppable in the cycle after N.
  - In FWFT = 1 it is visible on out after edge N.
- Read latency, FWFT = 0: out valid after the edge at which pop is accepted (1 cycle).
- Read latency, FWFT = 1: out is valid with empty = 0, zero cycles; pop consumes it.
- Throughput: one write and one read per cycle sustained. No bubbles at pointer wrap-around.
- Pointer wrap: pointers roll from DEPTH−1 to 0 transparently. Occupancy comes only from num, never from pointer comparison.
- Reset mid-operation: all state is cleared at that edge. The first accepted write after reset is stored at address 0.

## Test plan
- Reset, then push 0..15 on 16 consecutive cycles (DEPTH = 16) -> num = 16, full = 1, almostfull = 1 with af_level = 14; 17th push (value 16) -> overflow = 1, num stays 16, value 16 never read.
- From full, push + pop for 8 cycles (in = 100..107) -> num stays 16, overflow unchanged.
  - FWFT = 0: out sequence after each pop edge is 0..7.
  - Then drain: 8..15 then 100..107.
- Reset, then pop with empty = 1 -> underflow = 1, num = 0, out = 0. Same cycle push + pop on empty -> num = 1, underflow = 1.
- ae_level = 2, af_level = 14 -> push 3 words: almostempty 1, 1, 1→0 after 3rd write; push to 14: almostfull asserts after 14th write.
- FWFT = 1: push 0xABCD at edge N -> out = 0xABCD in cycle after N with empty = 0; pop -> empty = 1, out = 0.
- Fill 10 words, drain 5, assert clear -> num = 0, empty = 1, peak = 0, error flags 0, out holds last value. Separately, reset = 0 mid-stream -> identical state, out = 0.
